sqrt_req_arbiter: RTL

//  Shares one multi-cycle fp16 sqrt core (classify -> normalize -> root -> pack) among NREQ requesters.

---
 rtl/sqrt_req_arbiter.sv | 87 ++++++++
 1 files changed

// File: rtl/sqrt_req_arbiter.sv
// sqrt_req_arbiter: round-robin sharing of one multi-cycle fp16 sqrt core, with a done timeout
module sqrt_req_arbiter #(
  parameter int NREQ = 4,
  parameter int TIMEOUT = 64,
  localparam int IDW = $clog2(NREQ),
  localparam int TW = $clog2(TIMEOUT + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [16*NREQ-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic               core_start,
  output logic [15:0]        core_x,
  input  logic               core_done,
  input  logic [15:0]        core_result,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IDW-1:0]     rsp_id,
  output logic [15:0]        rsp_data,
  output logic               rsp_timeout,
  output logic               busy
);
  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic [IDW-1:0] ptr, win, id_reg;
  logic [IDW:0] s;
  logic any, take, done, tmo;
  logic [TW-1:0] timer;
  logic [15:0] x_reg;
  // Scan downward so the requester closest to ptr is the last (winning) assignment
  always_comb begin
    win = '0;
    any = 1'b0;
    s = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      s = {1'b0, ptr} + (IDW+1)'(k);
      s = s >= (IDW+1)'(NREQ) ? s - (IDW+1)'(NREQ) : s;
      if (req_valid[s[IDW-1:0]]) begin
        win = s[IDW-1:0];
        any = 1'b1;
      end
    end
  end
  assign take = state == IDLE && any;
  assign done = state == WAIT && core_done;
  assign tmo = state == WAIT && timer == TW'(TIMEOUT - 1);
  assign req_ready = take ? NREQ'(1) << win : '0;
  assign core_start = state == START;
  assign core_x = x_reg;
  assign rsp_valid = state == RESP;
  assign rsp_id = id_reg;
  assign busy = state != IDLE;
  always_comb begin
    state_nx = state == IDLE ? (any ? START : IDLE) :
               state == START ? WAIT :
               state == WAIT ? (core_done || tmo ? RESP : WAIT) :
               (rsp_ready ? IDLE : RESP);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      timer <= '0;
      x_reg <= '0;
      id_reg <= '0;
      rsp_data <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      state <= state_nx;
      if (take) begin
        x_reg <= req_data[{win, 4'b0000} +: 16];
        id_reg <= win;
        ptr <= win == IDW'(NREQ - 1) ? '0 : win + IDW'(1);
      end
      if (state == START) timer <= '0;
      else if (state == WAIT) timer <= timer + TW'(1);
      if (done) begin
        rsp_data <= core_result;
        rsp_timeout <= 1'b0;
      end else if (tmo) begin
        rsp_data <= 16'h7E00;
        rsp_timeout <= 1'b1;
      end
    end
  end
endmodule
